count_wrap_tracker: RTL and testbench

Downstream companion to the 4-bit up/down counter. It samples the counter's 4-bit output every rising clock edge and detects wrap-around in either direction (15→0 counting up, 0→15 counting down). It keeps an upper-order wrap count so the system sees a wider extended position value, and it flags any illegal counter step. Its input is taken directly from the counter's `out` bus. The counter updates on the falling edge of the same clock, so the value is stable at this block's sampling edge.

---
 rtl/count_wrap_tracker.sv | 110 +++++++++++
 tb/tb_count_wrap_tracker.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/count_wrap_tracker.sv
// count_wrap_tracker
//
// Watches the 4-bit output of an up/down counter and extends it with an
// upper-order wrap count. It samples on every rising edge. When the counter
// rolls over 15->0 the wrap count goes up by one. When it rolls over 0->15
// the wrap count goes down by one. A jump that is not +1, -1 or 0 (mod 16)
// is flagged.
//
// Parameters:
//   HI_W       width of the wrap (upper-order) counter
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   count_in   4-bit value from the upstream counter
//   clr        synchronous clear, same effect as reset
//   ext_count  extended position {hi, lo}
//   primed     high once a baseline sample has been taken
//   wrap_up    one-cycle pulse on a 15->0 wrap
//   wrap_down  one-cycle pulse on a 0->15 wrap
//   step_err   sticky flag for an illegal step
//   hi_ovf     sticky flag set when hi itself wraps
module count_wrap_tracker #(
  parameter int HI_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [3:0]      count_in,
  input  logic            clr,
  output logic [HI_W+3:0] ext_count,
  output logic            primed,
  output logic            wrap_up,
  output logic            wrap_down,
  output logic            step_err,
  output logic            hi_ovf
);

  typedef enum logic {
    IDLE,
    TRACK
  } state_t;

  state_t          state;
  logic [3:0]      lo;
  logic [HI_W-1:0] hi;
  logic [3:0]      delta;

  // lo always holds the last sampled value, so it also serves as the
  // previous sample when the next step is classified. The 4-bit subtraction
  // gives the step size modulo 16 without extra logic.
  assign delta     = count_in - lo;
  assign ext_count = {hi, lo};

  // Main state machine. All outputs are registered here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      lo        <= '0;
      hi        <= '0;
      primed    <= 1'b0;
      wrap_up   <= 1'b0;
      wrap_down <= 1'b0;
      step_err  <= 1'b0;
      hi_ovf    <= 1'b0;
    end else if (clr) begin
      state     <= IDLE;
      lo        <= '0;
      hi        <= '0;
      primed    <= 1'b0;
      wrap_up   <= 1'b0;
      wrap_down <= 1'b0;
      step_err  <= 1'b0;
      hi_ovf    <= 1'b0;
    end else begin
      wrap_up   <= 1'b0;
      wrap_down <= 1'b0;
      lo        <= count_in;
      case (state)
        IDLE: begin
          // The priming edge only takes a baseline. No earlier sample
          // exists, so no step can be classified yet.
          hi     <= '0;
          primed <= 1'b1;
          state  <= TRACK;
        end
        TRACK: begin
          if (delta == 4'd1) begin
            // An up-step from 15 can only land on 0, so this is a wrap.
            if (lo == 4'hF) begin
              hi      <= hi + 1'b1;
              wrap_up <= 1'b1;
              if (&hi) hi_ovf <= 1'b1;
            end
          end else if (delta == 4'hF) begin
            // A down-step from 0 can only land on 15, so this is a wrap.
            if (lo == 4'h0) begin
              hi        <= hi - 1'b1;
              wrap_down <= 1'b1;
              if (hi == '0) hi_ovf <= 1'b1;
            end
          end else if (delta != 4'd0) begin
            step_err <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_count_wrap_tracker.sv
// tb_count_wrap_tracker
//
// Self-checking bench for count_wrap_tracker with HI_W = 8.
// Inputs change on the falling edge, as the upstream counter does. The
// expected observation for each edge is queued when the stimulus is driven.
// It is popped and compared #1 after the rising edge.
module tb_count_wrap_tracker;

  logic        clk;
  logic        reset;
  logic [3:0]  count_in;
  logic        clr;
  logic [11:0] ext_count;
  logic        primed;
  logic        wrap_up;
  logic        wrap_down;
  logic        step_err;
  logic        hi_ovf;

  count_wrap_tracker #(.HI_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .count_in  (count_in),
    .clr       (clr),
    .ext_count (ext_count),
    .primed    (primed),
    .wrap_up   (wrap_up),
    .wrap_down (wrap_down),
    .step_err  (step_err),
    .hi_ovf    (hi_ovf)
  );

  // Free-running clock with a 10-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] ext;
    logic        primed;
    logic        wu;
    logic        wd;
    logic        serr;
    logic        ovf;
  } obs_t;

  typedef struct {
    logic [3:0] cin;
    logic       c;
    obs_t       exp;
  } vec_t;

  obs_t sb_q[$];
  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic obs_t mk(logic [11:0] e, logic p, logic wu, logic wd,
                              logic se, logic ov);
    obs_t o;
    o.ext    = e;
    o.primed = p;
    o.wu     = wu;
    o.wd     = wd;
    o.serr   = se;
    o.ovf    = ov;
    return o;
  endfunction

  function automatic void addv(logic [3:0] cin, logic c, obs_t exp);
    vec_t v;
    v.cin = cin;
    v.c   = c;
    v.exp = exp;
    vecs.push_back(v);
  endfunction

  function automatic obs_t sample();
    return mk(ext_count, primed, wrap_up, wrap_down, step_err, hi_ovf);
  endfunction

  // Drive one counter value on the falling edge and queue its expectation.
  task automatic applyStimulus(input logic [3:0] cin, input logic c,
                               input obs_t exp);
    @(negedge clk);
    count_in = cin;
    clr      = c;
    sb_q.push_back(exp);
    @(posedge clk);
    #1;
  endtask

  // Compare the DUT against the oldest queued expectation.
  task automatic checkOutput(input string name);
    obs_t act;
    obs_t exp;
    act = sample();
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_bad++;
      $display("[TB] FAIL %s: scoreboard empty, got %h", name, act);
      return;
    end
    exp = sb_q.pop_front();
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got ext=%h p=%b up=%b dn=%b err=%b ovf=%b, want ext=%h p=%b up=%b dn=%b err=%b ovf=%b",
               name, act.ext, act.primed, act.wu, act.wd, act.serr, act.ovf,
               exp.ext, exp.primed, exp.wu, exp.wd, exp.serr, exp.ovf);
    end
  endtask

  // Direct comparison for checks that do not follow a clock edge.
  task automatic checkNow(input string name, input obs_t exp);
    obs_t act;
    act = sample();
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached, ran %0d comparisons", n_cmp);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    obs_t        zero;
    logic [7:0]  hi_m;
    logic [3:0]  val;
    logic        ovf_m;

    zero = mk(12'h000, 0, 0, 0, 0, 0);

    // Reset and prime.
    reset    = 1'b0;
    clr      = 1'b0;
    count_in = 4'd7;
    #3;
    checkNow("reset_values", zero);
    @(posedge clk);
    #1;
    checkNow("reset_held_over_edge", zero);
    @(negedge clk);
    reset    = 1'b1;
    count_in = 4'd7;
    sb_q.push_back(mk(12'h007, 1, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    checkOutput("prime_at_7");

    // Vector table: {count_in, clr, expected observation after the edge}.
    // Up wrap.
    addv(4'd0,  1, zero);
    addv(4'd14, 0, mk(12'h00E, 1, 0, 0, 0, 0));
    addv(4'd15, 0, mk(12'h00F, 1, 0, 0, 0, 0));
    addv(4'd0,  0, mk(12'h010, 1, 1, 0, 0, 0));
    addv(4'd1,  0, mk(12'h011, 1, 0, 0, 0, 0));
    // Down wrap that underflows hi.
    addv(4'd0,  1, zero);
    addv(4'd1,  0, mk(12'h001, 1, 0, 0, 0, 0));
    addv(4'd0,  0, mk(12'h000, 1, 0, 0, 0, 0));
    addv(4'd15, 0, mk(12'hFFF, 1, 0, 1, 0, 1));
    addv(4'd14, 0, mk(12'hFFE, 1, 0, 0, 0, 1));
    // Reversal: up wrap immediately followed by a down wrap.
    addv(4'd0,  1, zero);
    addv(4'd15, 0, mk(12'h00F, 1, 0, 0, 0, 0));
    addv(4'd0,  0, mk(12'h010, 1, 1, 0, 0, 0));
    addv(4'd15, 0, mk(12'h00F, 1, 0, 1, 0, 0));
    // Illegal step, sticky flag, then clr and re-prime.
    addv(4'd0,  1, zero);
    addv(4'd3,  0, mk(12'h003, 1, 0, 0, 0, 0));
    addv(4'd9,  0, mk(12'h009, 1, 0, 0, 1, 0));
    addv(4'd10, 0, mk(12'h00A, 1, 0, 0, 1, 0));
    addv(4'd10, 0, mk(12'h00A, 1, 0, 0, 1, 0));
    addv(4'd10, 1, zero);
    addv(4'd5,  0, mk(12'h005, 1, 0, 0, 0, 0));
    addv(4'd5,  0, mk(12'h005, 1, 0, 0, 0, 0));
    addv(4'd4,  0, mk(12'h004, 1, 0, 0, 0, 0));
    // No wrap may be reported across a clear (15, clr, 0).
    addv(4'd0,  1, zero);
    addv(4'd15, 0, mk(12'h00F, 1, 0, 0, 0, 0));
    addv(4'd0,  1, zero);
    addv(4'd0,  0, mk(12'h000, 1, 0, 0, 0, 0));
    addv(4'd15, 0, mk(12'hFFF, 1, 0, 1, 0, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].cin, vecs[i].c, vecs[i].exp);
      checkOutput($sformatf("vec[%0d]", i));
    end

    // 256 up-wraps bring hi back to 0 and set hi_ovf.
    applyStimulus(4'd0, 1'b1, zero);
    checkOutput("ovf_clr");
    applyStimulus(4'd0, 1'b0, mk(12'h000, 1, 0, 0, 0, 0));
    checkOutput("ovf_prime");
    hi_m  = 8'h00;
    ovf_m = 1'b0;
    for (int w = 0; w < 256; w++) begin
      for (int v = 1; v <= 16; v++) begin
        val = 4'(v);
        if (val == 4'd0) begin
          if (hi_m == 8'hFF) ovf_m = 1'b1;
          hi_m = hi_m + 8'd1;
        end
        applyStimulus(val, 1'b0,
                      mk({hi_m, val}, 1, (val == 4'd0), 0, 0, ovf_m));
        checkOutput($sformatf("wrap%0d_v%0d", w, v));
      end
    end
    applyStimulus(4'd1, 1'b0, mk(12'h001, 1, 0, 0, 0, 1));
    checkOutput("after_256_wraps");

    // Asynchronous reset between edges.
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    checkNow("async_reset_midcycle", zero);
    @(posedge clk);
    #1;
    checkNow("async_reset_held", zero);
    @(negedge clk);
    reset    = 1'b1;
    count_in = 4'd7;
    sb_q.push_back(mk(12'h007, 1, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    checkOutput("reprime_after_reset");

    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("[TB] FAIL scoreboard_drain: %0d left, want 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
